// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryptor: 1 or 2 rounds per clock, on-the-fly key expansion, valid/ready on both sides.
// Define AES_ITER_CORE_CTR_EN to add counter mode and the ctr_load input; otherwise the core is plain ECB.
`timescale 1ns/1ps
module aes_iter_core #(
   parameter int KEY_BITS         = 128,
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        plain_text,
   input  logic [KEY_BITS-1:0] key_in,
`ifdef AES_ITER_CORE_CTR_EN
   input  logic                ctr_load,
`endif
   input  logic                restart,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        cipher_text,
   output logic                busy
);
   localparam int NR = (KEY_BITS == 256) ? 14 : 10;
   localparam int NC = NR / ROUNDS_PER_CYCLE;
   localparam int CW = $clog2(NC + 1);

   if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
      $fatal(1, "aes_iter_core: ROUNDS_PER_CYCLE must be 1 or 2");
   end
   if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
      $fatal(1, "aes_iter_core: KEY_BITS must be 128 or 256");
   end

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse as a^254 (product of a^2 .. a^128), which also maps 0 to 0.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] sq;
      inv = 8'h01;
      sq  = a;
      for (int i = 1; i < 8; i++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++)
            t[rr+4*c] = b[rr + 4*((c+rr) % 4)];
      for (int c = 0; c < 4; c++) begin
         a0 = t[4*c];
         a1 = t[4*c+1];
         a2 = t[4*c+2];
         a3 = t[4*c+3];
         if (last) begin
            r[127-32*c -: 32] = {a0, a1, a2, a3};
         end else begin
            r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
         end
      end
      return r ^ rk;
   endfunction

   // One 128-bit key-schedule step; the 256-bit window slides by one group, the 128-bit one is replaced.
   function automatic logic [KEY_BITS-1:0] key_step(input logic [KEY_BITS-1:0] w,
                                                    input logic [7:0] rc, input logic odd);
      logic [127:0] a;
      logic [127:0] n;
      logic [31:0]  lw;
      logic [31:0]  tmp;
      a  = w[KEY_BITS-1 -: 128];
      lw = w[31:0];
      if (odd) tmp = sub_word(lw);
      else     tmp = sub_word({lw[23:0], lw[31:24]}) ^ {rc, 24'h0};
      n[127:96] = a[127:96] ^ tmp;
      n[95:64]  = a[95:64]  ^ n[127:96];
      n[63:32]  = a[63:32]  ^ n[95:64];
      n[31:0]   = a[31:0]   ^ n[63:32];
      return KEY_BITS'({w[127:0], n});
   endfunction

   state_t                state_q, state_d;
   logic [CW-1:0]         rcnt_q, rcnt_d;
   logic [127:0]          blk_q, blk_d;
   logic [KEY_BITS-1:0]   key_q, key_d;
   logic [7:0]            rcon_q, rcon_d;
   logic                  par_q, par_d;
   logic [127:0]          cipher_q, cipher_d;
   logic                  accept, hs;
   logic [127:0]          src, mask;
`ifdef AES_ITER_CORE_CTR_EN
   logic [127:0]          ctr_q, ctr_d, data_q, data_d;
   logic                  ctr_vld_q, ctr_vld_d, xor_q, xor_d;
`endif

   logic [127:0]          st_w  [ROUNDS_PER_CYCLE+1];
   logic [KEY_BITS-1:0]   win_w [ROUNDS_PER_CYCLE+1];
   logic [7:0]            rc_w  [ROUNDS_PER_CYCLE+1];
   logic                  par_w [ROUNDS_PER_CYCLE+1];

   assign st_w[0]  = blk_q;
   assign win_w[0] = key_q;
   assign rc_w[0]  = rcon_q;
   assign par_w[0] = par_q;

   for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
      logic [KEY_BITS-1:0] win_next;
      logic [127:0]        rk;
      logic                last_rnd;
      assign win_next     = key_step(win_w[gi], rc_w[gi], par_w[gi]);
      assign rk           = (KEY_BITS == 256) ? win_w[gi][127:0] : win_next[127:0];
      assign last_rnd     = (int'(rcnt_q) * ROUNDS_PER_CYCLE + gi + 1) == NR;
      assign st_w[gi+1]   = aes_round(st_w[gi], rk, last_rnd);
      assign win_w[gi+1]  = win_next;
      assign rc_w[gi+1]   = par_w[gi] ? rc_w[gi] : xtime(rc_w[gi]);
      assign par_w[gi+1]  = (KEY_BITS == 256) ? ~par_w[gi] : 1'b0;
   end

   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      blk_d     = blk_q;
      key_d     = key_q;
      rcon_d    = rcon_q;
      par_d     = par_q;
      cipher_d  = cipher_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      hs        = 1'b0;
      src       = plain_text;
      mask      = '0;
`ifdef AES_ITER_CORE_CTR_EN
      ctr_d     = ctr_q;
      ctr_vld_d = ctr_vld_q;
      xor_d     = xor_q;
      data_d    = data_q;
      if (xor_q) mask = data_q;
`endif
      case (state_q)
         IDLE: in_ready = 1'b1;
         ROUND: begin
            busy = 1'b1;
            if (rcnt_q == CW'(NC)) begin
               cipher_d = blk_q ^ mask;
               state_d  = DONE;
            end else begin
               blk_d  = st_w[ROUNDS_PER_CYCLE];
               key_d  = win_w[ROUNDS_PER_CYCLE];
               rcon_d = rc_w[ROUNDS_PER_CYCLE];
               par_d  = par_w[ROUNDS_PER_CYCLE];
               rcnt_d = rcnt_q + CW'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready && !restart;
            hs        = out_ready;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      accept = in_valid && in_ready;
`ifdef AES_ITER_CORE_CTR_EN
      if (hs) ctr_d = {ctr_q[127:32], ctr_q[31:0] + 32'd1};
      if (accept) begin
         if (ctr_load || !ctr_vld_q) begin
            ctr_d     = plain_text;
            ctr_vld_d = 1'b1;
            xor_d     = 1'b0;
         end else begin
            src    = ctr_d;
            xor_d  = 1'b1;
            data_d = plain_text;
         end
      end
`endif
      if (accept) begin
         blk_d   = src ^ key_in[KEY_BITS-1 -: 128];
         key_d   = key_in;
         rcon_d  = 8'h01;
         par_d   = 1'b0;
         rcnt_d  = '0;
         state_d = ROUND;
      end
      if (restart && state_q != IDLE) begin
         state_d = IDLE;
`ifdef AES_ITER_CORE_CTR_EN
         ctr_vld_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rcnt_q    <= '0;
         blk_q     <= '0;
         key_q     <= '0;
         rcon_q    <= '0;
         par_q     <= 1'b0;
         cipher_q  <= '0;
`ifdef AES_ITER_CORE_CTR_EN
         ctr_q     <= '0;
         data_q    <= '0;
         ctr_vld_q <= 1'b0;
         xor_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         blk_q     <= blk_d;
         key_q     <= key_d;
         rcon_q    <= rcon_d;
         par_q     <= par_d;
         cipher_q  <= cipher_d;
`ifdef AES_ITER_CORE_CTR_EN
         ctr_q     <= ctr_d;
         data_q    <= data_d;
         ctr_vld_q <= ctr_vld_d;
         xor_q     <= xor_d;
`endif
      end
   end

   assign cipher_text = cipher_q;

endmodule
